// File: rtl/pc_pkg.sv
// Shared definitions for the program-counter sequencer: state encoding,
// PC width and the default reset vector.
package pc_pkg;

   localparam int PC_WIDTH = 16;
   localparam logic [PC_WIDTH-1:0] RESET_VEC_DEF = 16'h0000;

   typedef enum logic [1:0] {
      RST_S  = 2'd0,
      FETCH  = 2'd1,
      UPDATE = 2'd2,
      HALT   = 2'd3
   } state_t;

endpackage

// File: rtl/full_adder.sv
// Single-bit full adder cell used by the ripple-carry branch adder.
module full_adder (
   input  logic a,
   input  logic b,
   input  logic cin,
   output logic sum,
   output logic cout
);

   assign sum  = a ^ b ^ cin;
   assign cout = (a & b) | (cin & (a ^ b));

endmodule

// File: rtl/pc_branch_adder.sv
// Ripple-carry adder producing the PC-relative branch target pc_inc + offset.
// The carry-in is tied low and the final carry-out is dropped, so the result
// wraps modulo 2^WIDTH and negative offsets work as two's complement.
module pc_branch_adder #(
   parameter int WIDTH = 16
) (
   input  logic [WIDTH-1:0] a,
   input  logic [WIDTH-1:0] b,
   output logic [WIDTH-1:0] sum
);

   logic [WIDTH-1:0] carry;
   logic             cout_unused;

   assign carry[0] = 1'b0;

   for (genvar i = 0; i < WIDTH; i++) begin : g_bit
      if (i < WIDTH - 1) begin : g_mid
         full_adder u_fa (
            .a   (a[i]),
            .b   (b[i]),
            .cin (carry[i]),
            .sum (sum[i]),
            .cout(carry[i+1])
         );
      end else begin : g_msb
         full_adder u_fa (
            .a   (a[i]),
            .b   (b[i]),
            .cin (carry[i]),
            .sum (sum[i]),
            .cout(cout_unused)
         );
      end
   end

endmodule

// File: rtl/pc_sequencer.sv
// Program-counter register and fetch sequencer. Cycles FETCH -> UPDATE ->
// FETCH, handshaking with instruction memory in FETCH and choosing the next
// PC (halt > jump > branch > stall > increment) in UPDATE. All outputs are
// registered; the external incrementer returns pc+1 on pc_inc.
module pc_sequencer
   import pc_pkg::*;
#(
   parameter int               WIDTH     = PC_WIDTH,
   parameter logic [WIDTH-1:0] RESET_VEC = RESET_VEC_DEF
) (
   input  logic             clk,
   input  logic             rst,
   output logic [WIDTH-1:0] pc,
   input  logic [WIDTH-1:0] pc_inc,
   output logic             fetch_req,
   input  logic             fetch_ack,
   output logic             instr_valid,
   input  logic             stall,
   input  logic             br_taken,
   input  logic [WIDTH-1:0] br_offset,
   input  logic             jmp_en,
   input  logic [WIDTH-1:0] jmp_target,
   input  logic             halt,
   output logic             halted,
   output logic             wrap
);

   state_t           state;
   state_t           state_nxt;
   logic [WIDTH-1:0] pc_nxt;
   logic [WIDTH-1:0] br_target;
   logic             fetch_req_nxt;
   logic             instr_valid_nxt;
   logic             halted_nxt;
   logic             wrap_nxt;

   pc_branch_adder #(.WIDTH(WIDTH)) u_br_add (
      .a  (pc_inc),
      .b  (br_offset),
      .sum(br_target)
   );

   // Next-state, next-PC and next-output selection; registered below so every output is a flop.
   always_comb begin
      state_nxt       = state;
      pc_nxt          = pc;
      instr_valid_nxt = 1'b0;
      wrap_nxt        = 1'b0;
      case (state)
         RST_S: begin
            state_nxt = FETCH;
         end
         FETCH: begin
            if (fetch_ack) begin
               state_nxt       = UPDATE;
               instr_valid_nxt = 1'b1;
            end
         end
         UPDATE: begin
            if (halt) begin
               state_nxt = HALT;
            end else if (jmp_en) begin
               pc_nxt    = jmp_target;
               state_nxt = FETCH;
            end else if (br_taken) begin
               pc_nxt    = br_target;
               state_nxt = FETCH;
            end else if (stall) begin
               state_nxt = UPDATE;
            end else begin
               pc_nxt    = pc_inc;
               state_nxt = FETCH;
               // Only the sequential increment path reports a wrap.
               wrap_nxt  = &pc;
            end
         end
         HALT: begin
            state_nxt = HALT;
         end
         default: begin
            state_nxt = RST_S;
         end
      endcase
      fetch_req_nxt = (state_nxt == FETCH);
      halted_nxt    = (state_nxt == HALT);
   end

   // State, PC and output registers with synchronous reset.
   always_ff @(posedge clk) begin
      if (rst) begin
         state       <= RST_S;
         pc          <= RESET_VEC;
         fetch_req   <= 1'b0;
         instr_valid <= 1'b0;
         halted      <= 1'b0;
         wrap        <= 1'b0;
      end else begin
         state       <= state_nxt;
         pc          <= pc_nxt;
         fetch_req   <= fetch_req_nxt;
         instr_valid <= instr_valid_nxt;
         halted      <= halted_nxt;
         wrap        <= wrap_nxt;
      end
   end

endmodule

// File: tb/tb_pc_sequencer.sv
// Self-checking bench for pc_sequencer. The bench plays both the incrementer
// (pc_inc = pc + 1) and instruction memory. Each fetch pushes the address it
// expects to be reported; a monitor pops it when instr_valid pulses.
module tb_pc_sequencer;

   localparam int W = 16;

   logic         clk = 1'b0;
   logic         rst;
   logic [W-1:0] pc;
   logic [W-1:0] pc_inc;
   logic         fetch_req;
   logic         fetch_ack;
   logic         instr_valid;
   logic         stall;
   logic         br_taken;
   logic [W-1:0] br_offset;
   logic         jmp_en;
   logic [W-1:0] jmp_target;
   logic         halt;
   logic         halted;
   logic         wrap;

   int           checks = 0;
   int           errors = 0;
   logic [W-1:0] exp_q[$];

   always #5 clk = ~clk;

   assign pc_inc = pc + 16'd1;

   pc_sequencer #(.WIDTH(16), .RESET_VEC(16'h0000)) dut (
      .clk        (clk),
      .rst        (rst),
      .pc         (pc),
      .pc_inc     (pc_inc),
      .fetch_req  (fetch_req),
      .fetch_ack  (fetch_ack),
      .instr_valid(instr_valid),
      .stall      (stall),
      .br_taken   (br_taken),
      .br_offset  (br_offset),
      .jmp_en     (jmp_en),
      .jmp_target (jmp_target),
      .halt       (halt),
      .halted     (halted),
      .wrap       (wrap)
   );

   task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
      checks++;
      if (got !== exp) begin
         errors++;
         $display("FAIL %s got=%h exp=%h", tag, got, exp);
      end
   endtask

   // Incrementer contract and scoreboard pop on every fetched instruction.
   always @(negedge clk) begin
      if (rst === 1'b0) begin
         assert (pc_inc == pc + 16'd1);
      end
      if (instr_valid === 1'b1) begin
         chk("sb_nonempty", 32'(exp_q.size() > 0), 32'd1);
         if (exp_q.size() > 0) chk("sb_pc", pc, exp_q.pop_front());
      end
   end

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic clear_ctl();
      stall      = 1'b0;
      br_taken   = 1'b0;
      br_offset  = '0;
      jmp_en     = 1'b0;
      jmp_target = '0;
      halt       = 1'b0;
   endtask

   // Called in the first FETCH cycle; memory answers after lat wait cycles.
   task automatic do_fetch(input int lat, input logic [W-1:0] a);
      exp_q.push_back(a);
      for (int i = 0; i < lat; i++) begin
         chk("req_wait", fetch_req, 1);
         chk("pc_hold", pc, a);
         chk("iv_wait", instr_valid, 0);
         tick();
      end
      chk("req_fetch", fetch_req, 1);
      chk("pc_fetch", pc, a);
      chk("iv_fetch", instr_valid, 0);
      fetch_ack = 1'b1;
      tick();
      fetch_ack = 1'b0;
      chk("req_drop", fetch_req, 0);
      chk("iv_pulse", instr_valid, 1);
   endtask

   // Called in the UPDATE cycle: apply controls for one edge, then check the new PC.
   task automatic do_update(input string tag, input logic br, input logic [W-1:0] off,
                            input logic jmp, input logic [W-1:0] tgt,
                            input logic [W-1:0] exp_pc, input logic exp_wrap);
      br_taken   = br;
      br_offset  = off;
      jmp_en     = jmp;
      jmp_target = tgt;
      tick();
      clear_ctl();
      chk(tag, pc, exp_pc);
      chk("wrap", wrap, exp_wrap);
      chk("req_after_upd", fetch_req, 1);
      chk("iv_after_upd", instr_valid, 0);
   endtask

   initial begin
      clear_ctl();
      rst       = 1'b1;
      fetch_ack = 1'b1;
      repeat (3) tick();
      chk("rst_pc", pc, 16'h0000);
      chk("rst_req", fetch_req, 0);
      chk("rst_iv", instr_valid, 0);
      chk("rst_halted", halted, 0);
      chk("rst_wrap", wrap, 0);
      rst       = 1'b0;
      fetch_ack = 1'b0;
      tick();

      // Sequential fetches, memory answering one cycle after the request.
      do_fetch(1, 16'h0000);
      do_update("inc0", 0, 16'h0, 0, 16'h0, 16'h0001, 0);
      do_fetch(1, 16'h0001);
      do_update("inc1", 0, 16'h0, 0, 16'h0, 16'h0002, 0);
      do_fetch(1, 16'h0002);
      do_update("inc2", 0, 16'h0, 0, 16'h0, 16'h0003, 0);

      // Slow memory.
      do_fetch(5, 16'h0003);

      // Jump, negative branch, jump beating branch.
      do_update("jmp10", 0, 16'h0, 1, 16'h0010, 16'h0010, 0);
      do_fetch(0, 16'h0010);
      do_update("br_neg", 1, 16'hFFF0, 0, 16'h0, 16'h0001, 0);
      do_fetch(0, 16'h0001);
      do_update("jmp_wins", 1, 16'h0005, 1, 16'h1234, 16'h1234, 0);
      do_fetch(0, 16'h1234);

      // Stall holds in UPDATE; a stray ack meanwhile is ignored.
      stall     = 1'b1;
      fetch_ack = 1'b1;
      for (int i = 0; i < 4; i++) begin
         tick();
         chk("stall_pc", pc, 16'h1234);
         chk("stall_req", fetch_req, 0);
         chk("stall_iv", instr_valid, 0);
      end
      stall     = 1'b0;
      fetch_ack = 1'b0;
      do_update("stall_rel", 0, 16'h0, 0, 16'h0, 16'h1235, 0);
      do_fetch(0, 16'h1235);

      // Wrap on increment only.
      do_update("jmp_ffff", 0, 16'h0, 1, 16'hFFFF, 16'hFFFF, 0);
      do_fetch(0, 16'hFFFF);
      do_update("inc_wrap", 0, 16'h0, 0, 16'h0, 16'h0000, 1);
      tick();
      chk("wrap_one_cycle", wrap, 0);
      do_fetch(0, 16'h0000);
      do_update("jmp_zero", 0, 16'h0, 1, 16'h0000, 16'h0000, 0);
      do_fetch(0, 16'h0000);
      do_update("br_wrapneg", 1, 16'hFFFE, 0, 16'h0, 16'hFFFF, 0);
      do_fetch(0, 16'hFFFF);
      do_update("br_to_zero", 1, 16'h0000, 0, 16'h0, 16'h0000, 0);
      do_fetch(0, 16'h0000);

      // Halt beats jump and then ignores everything but reset.
      halt       = 1'b1;
      jmp_en     = 1'b1;
      jmp_target = 16'h5555;
      tick();
      clear_ctl();
      chk("halt_halted", halted, 1);
      chk("halt_req", fetch_req, 0);
      chk("halt_pc", pc, 16'h0000);
      for (int i = 0; i < 10; i++) begin
         jmp_en     = 1'b1;
         jmp_target = 16'hA5A5;
         br_taken   = 1'b1;
         br_offset  = 16'h0100;
         fetch_ack  = i[0];
         tick();
         chk("halt_hold_pc", pc, 16'h0000);
         chk("halt_hold_flag", halted, 1);
         chk("halt_hold_req", fetch_req, 0);
         chk("halt_hold_iv", instr_valid, 0);
      end
      clear_ctl();
      fetch_ack = 1'b0;

      // Reset leaves HALT.
      rst = 1'b1;
      tick();
      chk("unhalt", halted, 0);
      rst = 1'b0;
      tick();
      do_fetch(0, 16'h0000);
      do_update("inc_post_rst", 0, 16'h0, 0, 16'h0, 16'h0001, 0);

      // Reset during FETCH with a same-cycle ack abandons the fetch.
      rst       = 1'b1;
      fetch_ack = 1'b1;
      tick();
      chk("midrst_pc", pc, 16'h0000);
      chk("midrst_iv", instr_valid, 0);
      chk("midrst_req", fetch_req, 0);
      rst = 1'b0;
      tick();
      chk("ack_in_rst_iv", instr_valid, 0);
      chk("ack_in_rst_req", fetch_req, 1);
      fetch_ack = 1'b0;
      do_fetch(0, 16'h0000);
      tick();

      chk("sb_drain", 32'(exp_q.size()), 32'd0);
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
